fpga2cpu_queue_state: RTL and testbench
=======================================

# fpga2cpu_queue_state

Per-queue CPU ring-buffer state store feeding `fpga2cpu_pcie`. On each `dma_start`, it looks up the target queue's `head`, `tail` and `kmem_addr`, then presents them with `queue_ready` until `dma_done`. It then writes the returned `out_tail` back. CPU MMIO writes update per-queue `head` and configure/reset queues.

## Interface

Parameters:
- `NB_QUEUES`, default `1<<APP_IDX_WIDTH`: number of CPU queues.
- `RB_AWIDTH`, default package value: width of `head`/`tail` in 64 B slots.
- `APP_IDX_WIDTH`, default package value: queue index width.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  reset; synchronous, active-high.
- `dma_start`  in  1  level from ring buffer; a DMA is pending.
- `dma_queue`  in  APP_IDX_WIDTH  target queue; stable while `dma_start`=1.
- `dma_done`  in  1  one-cycle pulse; the DMA is finished.
- `out_tail`  in  RB_AWIDTH  new tail; valid when `dma_done`=1.
- `queue_ready`  out  1  `head`/`tail`/`kmem_addr` are valid for the active queue.
- `head`  out  RB_AWIDTH  active queue head, tracked live.
- `tail`  out  RB_AWIDTH  active queue tail.
- `kmem_addr`  out  64  active queue host base address.
- `cfg_wr_en`  in  1  MMIO write strobe.
- `cfg_wr_queue`  in  APP_IDX_WIDTH  queue written.
- `cfg_wr_sel`  in  2  0=head, 1=kmem_addr[31:0], 2=kmem_addr[63:32] (also resets head/tail), 3=ignored.
- `cfg_wr_data`  in  32  write data; `head` uses the low RB_AWIDTH bits.
- `cfg_rd_en`  in  1  tail readback request.
- `cfg_rd_queue`  in  APP_IDX_WIDTH  queue read.
- `cfg_rd_data`  out  RB_AWIDTH  tail of `cfg_rd_queue`.
- `cfg_rd_valid`  out  1  one-cycle pulse, 1 cycle after `cfg_rd_en`.

## Operation

- **Storage:** register arrays `head_mem`, `tail_mem`, `kaddr_mem`, each of depth NB_QUEUES. All entries reset to 0.
- **FSM states:** IDLE, LOOKUP, READY.
  - IDLE: if `dma_start`=1, latch `active_q` <= `dma_queue` and go to LOOKUP.
  - LOOKUP: load the output registers from the arrays at `active_q`, assert `queue_ready`, go to READY.
  - READY: hold `queue_ready`=1. On `dma_done`: `tail_mem[active_q]` <= `out_tail`, `queue_ready` <= 0, go to IDLE.
- **Live head:**
  - During LOOKUP/READY, a `cfg_wr_en` with sel 0 to `active_q` also updates the `head` output on the next cycle. This lets `fpga2cpu_pcie` see freed space while it stalls on free slots.
  - A sel 0 write in the same cycle as the LOOKUP load forwards the new value into the `head` output.
- **Stable fields:** `tail` and `kmem_addr` outputs do not change in READY.
- **Queue reset (sel 2):** writes `kmem_addr[63:32]` and zeroes `head_mem`/`tail_mem` of that queue. Software issues this only for queues idle on the DMA path.
- **Tail writeback collision:** if a sel 2 write targets `active_q` in the same cycle as `dma_done`, the zeroing wins.
- **Readback:** `cfg_rd_data` <= `tail_mem[cfg_rd_queue]`. The write-back from `dma_done` in the same cycle is forwarded, so the new tail is returned.
- **Ignored inputs:**
  - `dma_done` outside READY is ignored.
  - `dma_start` is sampled only in IDLE.
- **Widths:** all arithmetic is modulo RB_AWIDTH. No range check against `rb_size`; software keeps `head` < `rb_size`.

## Timing

- `dma_start` seen in IDLE at cycle N → LOOKUP at N+1 → `queue_ready`=1 and outputs valid from N+2.
- `dma_done` at cycle M → `queue_ready`=0 at M+1 and state IDLE at M+1. A still-asserted `dma_start` at M+1 starts the next lookup, so `queue_ready` returns at M+3.
- `head_mem` write latency is 1 cycle. Live `head` output update latency is 1 cycle.
- Readback latency is 1 cycle. Back-to-back reads are allowed every cycle.
- Outputs after reset:
  - `queue_ready`=0, `head`/`tail`=0, `kmem_addr`=0.
  - `cfg_rd_valid`=0, `cfg_rd_data`=0.
  - State IDLE.
- Reset mid-operation: abandon the lookup, zero all arrays, return to IDLE. No write-back occurs.

## Structure

- `APP_IDX_WIDTH`, `RB_AWIDTH` and the `cfg_wr_sel` encodings (`QS_SEL_HEAD`, `QS_SEL_KADDR_LO`, `QS_SEL_KADDR_HI`) belong in the shared struct/param package.
- The FSM state enum is local.
- Single flat module; no sub-module. The arrays are small enough for flops.

## Test plan

- **Basic lookup:** program queue 2 with `kmem_addr`=0x1_0000_4000 and `head`=5, then pulse `dma_start` with `dma_queue`=2 → at N+2, `queue_ready`=1, `head`=5, `tail`=0, `kmem_addr`=0x1_0000_4000. Then `dma_done` with `out_tail`=9 → a readback of queue 2 returns 9.
- **Live head:** in READY on queue 1, write `head`=30 to queue 1 → `head` output reads 30 one cycle later while `queue_ready` stays 1. A head write to queue 3 leaves the output unchanged.
- **Back-to-back DMAs:** hold `dma_start` on queue 0 then queue 1 → `queue_ready` drops for exactly 2 cycles between them. Queue 1's `tail` is unaffected by queue 0's write-back.
- **Collisions:**
  - Sel 2 write to `active_q` in the `dma_done` cycle → the tail reads 0.
  - `cfg_rd_en` on `active_q` in the `dma_done` cycle with `out_tail`=7 → returns 7.
- **Reset:** assert `rst` in READY → all outputs 0 next cycle; every queue reads back tail 0. `dma_done` after reset has no effect.

Source files
------------

// File: rtl/fpga2cpu_queue_state_pkg.sv
// Shared widths and MMIO select encodings for the CPU queue state store.
package fpga2cpu_queue_state_pkg;

  localparam int APP_IDX_WIDTH  = 2;
  localparam int RB_AWIDTH      = 10;
  localparam int KADDR_WIDTH    = 64;
  localparam int CFG_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    QS_SEL_HEAD     = 2'd0,
    QS_SEL_KADDR_LO = 2'd1,
    QS_SEL_KADDR_HI = 2'd2,
    QS_SEL_NONE     = 2'd3
  } qs_sel_e;

  // True when a write strobe carries the given field select.
  function automatic logic qs_sel_hit(input logic en, input logic [1:0] sel, input qs_sel_e want);
    return en && (qs_sel_e'(sel) == want);
  endfunction

endpackage

// File: rtl/fpga2cpu_queue_state_if.sv
// DMA handshake and MMIO config bus between the ring buffer / CPU side and the queue state store.
interface fpga2cpu_queue_state_if
  import fpga2cpu_queue_state_pkg::*;
#(
  parameter int APP_IDX_WIDTH = fpga2cpu_queue_state_pkg::APP_IDX_WIDTH,
  parameter int RB_AWIDTH     = fpga2cpu_queue_state_pkg::RB_AWIDTH
);

  logic                     dma_start;
  logic [APP_IDX_WIDTH-1:0] dma_queue;
  logic                     dma_done;
  logic [RB_AWIDTH-1:0]     out_tail;
  logic                     queue_ready;
  logic [RB_AWIDTH-1:0]     head;
  logic [RB_AWIDTH-1:0]     tail;
  logic [KADDR_WIDTH-1:0]   kmem_addr;

  logic                      cfg_wr_en;
  logic [APP_IDX_WIDTH-1:0]  cfg_wr_queue;
  logic [1:0]                cfg_wr_sel;
  logic [CFG_DATA_WIDTH-1:0] cfg_wr_data;
  logic                      cfg_rd_en;
  logic [APP_IDX_WIDTH-1:0]  cfg_rd_queue;
  logic [RB_AWIDTH-1:0]      cfg_rd_data;
  logic                      cfg_rd_valid;

  modport master (
    output dma_start, dma_queue, dma_done, out_tail,
    output cfg_wr_en, cfg_wr_queue, cfg_wr_sel, cfg_wr_data,
    output cfg_rd_en, cfg_rd_queue,
    input  queue_ready, head, tail, kmem_addr,
    input  cfg_rd_data, cfg_rd_valid
  );

  modport slave (
    input  dma_start, dma_queue, dma_done, out_tail,
    input  cfg_wr_en, cfg_wr_queue, cfg_wr_sel, cfg_wr_data,
    input  cfg_rd_en, cfg_rd_queue,
    output queue_ready, head, tail, kmem_addr,
    output cfg_rd_data, cfg_rd_valid
  );

endinterface

// File: rtl/fpga2cpu_queue_state.sv
// Per-queue CPU ring-buffer state: looks up head/tail/base address for each DMA,
// tracks head live while the DMA waits, and writes the final tail back.
module fpga2cpu_queue_state #(
  parameter int APP_IDX_WIDTH = fpga2cpu_queue_state_pkg::APP_IDX_WIDTH,
  parameter int RB_AWIDTH     = fpga2cpu_queue_state_pkg::RB_AWIDTH,
  parameter int NB_QUEUES     = 1 << APP_IDX_WIDTH
) (
  input logic                   clk,
  input logic                   rst,
  fpga2cpu_queue_state_if.slave bus
);

  import fpga2cpu_queue_state_pkg::*;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_READY  = 2'd2
  } state_e;

  state_e                   state_q, state_d;
  logic [APP_IDX_WIDTH-1:0] active_q, active_d;

  logic [RB_AWIDTH-1:0]   head_mem_q  [NB_QUEUES];
  logic [RB_AWIDTH-1:0]   tail_mem_q  [NB_QUEUES];
  logic [KADDR_WIDTH-1:0] kaddr_mem_q [NB_QUEUES];

  logic                   ready_q;
  logic [RB_AWIDTH-1:0]   head_q;
  logic [RB_AWIDTH-1:0]   tail_q;
  logic [KADDR_WIDTH-1:0] kaddr_q;
  logic [RB_AWIDTH-1:0]   rd_data_q;
  logic                   rd_valid_q;

  logic                 wr_head;
  logic                 wr_kaddr_lo;
  logic                 wr_kaddr_hi;
  logic [RB_AWIDTH-1:0] wr_head_data;
  logic                 head_hit_active;
  logic                 reset_hit_active;
  logic                 done_fire;
  logic                 tail_wb;

  // Decode MMIO strobes and the DMA write-back; a queue reset on the active queue beats the write-back.
  always_comb begin
    wr_head          = qs_sel_hit(bus.cfg_wr_en, bus.cfg_wr_sel, QS_SEL_HEAD);
    wr_kaddr_lo      = qs_sel_hit(bus.cfg_wr_en, bus.cfg_wr_sel, QS_SEL_KADDR_LO);
    wr_kaddr_hi      = qs_sel_hit(bus.cfg_wr_en, bus.cfg_wr_sel, QS_SEL_KADDR_HI);
    wr_head_data     = bus.cfg_wr_data[RB_AWIDTH-1:0];
    head_hit_active  = wr_head && (bus.cfg_wr_queue == active_q);
    reset_hit_active = wr_kaddr_hi && (bus.cfg_wr_queue == active_q);
    done_fire        = (state_q == ST_READY) && bus.dma_done;
    tail_wb          = done_fire && !reset_hit_active;
  end

  // Next-state logic: latch the queue on dma_start in IDLE, one lookup cycle, then wait for dma_done.
  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.dma_start) begin
          active_d = bus.dma_queue;
          state_d  = ST_LOOKUP;
        end
      end
      ST_LOOKUP: state_d = ST_READY;
      ST_READY: begin
        if (bus.dma_done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and active-queue registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      active_q <= '0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
    end
  end

  // Per-queue storage: MMIO writes, queue reset (base-high write), and the DMA tail write-back.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NB_QUEUES; i++) begin
        head_mem_q[i]  <= '0;
        tail_mem_q[i]  <= '0;
        kaddr_mem_q[i] <= '0;
      end
    end else begin
      if (tail_wb) begin
        tail_mem_q[active_q] <= bus.out_tail;
      end
      if (wr_head) begin
        head_mem_q[bus.cfg_wr_queue] <= wr_head_data;
      end
      if (wr_kaddr_lo) begin
        kaddr_mem_q[bus.cfg_wr_queue][31:0] <= bus.cfg_wr_data;
      end
      if (wr_kaddr_hi) begin
        kaddr_mem_q[bus.cfg_wr_queue][63:32] <= bus.cfg_wr_data;
        head_mem_q[bus.cfg_wr_queue]         <= '0;
        tail_mem_q[bus.cfg_wr_queue]         <= '0;
      end
    end
  end

  // Output registers: loaded in LOOKUP (with head forwarding), head tracked live in READY.
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q <= 1'b0;
      head_q  <= '0;
      tail_q  <= '0;
      kaddr_q <= '0;
    end else begin
      if (state_q == ST_LOOKUP) begin
        head_q  <= head_hit_active ? wr_head_data : head_mem_q[active_q];
        tail_q  <= tail_mem_q[active_q];
        kaddr_q <= kaddr_mem_q[active_q];
        ready_q <= 1'b1;
      end else if (state_q == ST_READY) begin
        if (head_hit_active) begin
          head_q <= wr_head_data;
        end
        if (bus.dma_done) begin
          ready_q <= 1'b0;
        end
      end
    end
  end

  // Tail readback, forwarding a same-cycle DMA write-back so software sees the new tail.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= bus.cfg_rd_en;
      if (bus.cfg_rd_en) begin
        if (tail_wb && (bus.cfg_rd_queue == active_q)) begin
          rd_data_q <= bus.out_tail;
        end else begin
          rd_data_q <= tail_mem_q[bus.cfg_rd_queue];
        end
      end
    end
  end

  assign bus.queue_ready  = ready_q;
  assign bus.head         = head_q;
  assign bus.tail         = tail_q;
  assign bus.kmem_addr    = kaddr_q;
  assign bus.cfg_rd_data  = rd_data_q;
  assign bus.cfg_rd_valid = rd_valid_q;

endmodule

// File: tb/tb_fpga2cpu_queue_state.sv
// Self-checking bench for fpga2cpu_queue_state: directed scenarios plus randomized
// DMA/MMIO traffic checked against a per-queue array model.
module tb_fpga2cpu_queue_state;

  import fpga2cpu_queue_state_pkg::*;

  localparam int NQ  = 1 << APP_IDX_WIDTH;
  localparam int RBW = RB_AWIDTH;

  logic clk = 1'b0;
  logic rst;

  // Free-running clock.
  always #5 clk = ~clk;

  fpga2cpu_queue_state_if #(.APP_IDX_WIDTH(APP_IDX_WIDTH), .RB_AWIDTH(RB_AWIDTH)) bus ();

  fpga2cpu_queue_state #(
    .APP_IDX_WIDTH(APP_IDX_WIDTH),
    .RB_AWIDTH(RB_AWIDTH),
    .NB_QUEUES(NQ)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [RBW-1:0]  mHead  [NQ];
  logic [RBW-1:0]  mTail  [NQ];
  logic [63:0]     mKaddr [NQ];
  logic            expReady;
  int              activeQ;
  logic [RBW-1:0]  snapTail;
  logic [63:0]     snapKaddr;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void modelZero();
    for (int i = 0; i < NQ; i++) begin
      mHead[i]  = '0;
      mTail[i]  = '0;
      mKaddr[i] = '0;
    end
  endfunction

  function automatic void modelWrite(input int q, input logic [1:0] sel, input logic [31:0] data);
    case (sel)
      2'd0: mHead[q] = data[RBW-1:0];
      2'd1: mKaddr[q][31:0] = data;
      2'd2: begin
        mKaddr[q][63:32] = data;
        mHead[q] = '0;
        mTail[q] = '0;
      end
      default: ;
    endcase
  endfunction

  task automatic driveIdle();
    bus.dma_start    = 1'b0;
    bus.dma_queue    = '0;
    bus.dma_done     = 1'b0;
    bus.out_tail     = '0;
    bus.cfg_wr_en    = 1'b0;
    bus.cfg_wr_queue = '0;
    bus.cfg_wr_sel   = 2'd0;
    bus.cfg_wr_data  = '0;
    bus.cfg_rd_en    = 1'b0;
    bus.cfg_rd_queue = '0;
  endtask

  task automatic checkState();
    checkOutput("queue_ready", 64'(bus.queue_ready), 64'(expReady));
    if (expReady) begin
      checkOutput("head", 64'(bus.head), 64'(mHead[activeQ]));
      checkOutput("tail", 64'(bus.tail), 64'(snapTail));
      checkOutput("kmem_addr", bus.kmem_addr, snapKaddr);
    end
  endtask

  // One cycle of MMIO traffic with no DMA event.
  task automatic applyStimulus(input bit wrEn, input int wq, input logic [1:0] sel, input logic [31:0] data,
                               input bit rdEn, input int rq);
    logic [RBW-1:0] expRd;
    expRd            = mTail[rq];
    bus.cfg_wr_en    = wrEn;
    bus.cfg_wr_queue = wq[APP_IDX_WIDTH-1:0];
    bus.cfg_wr_sel   = sel;
    bus.cfg_wr_data  = data;
    bus.cfg_rd_en    = rdEn;
    bus.cfg_rd_queue = rq[APP_IDX_WIDTH-1:0];
    if (wrEn) modelWrite(wq, sel, data);
    tick();
    bus.cfg_wr_en = 1'b0;
    bus.cfg_rd_en = 1'b0;
    checkState();
    checkOutput("rd_valid", 64'(bus.cfg_rd_valid), 64'(rdEn));
    if (rdEn) checkOutput("rd_data", 64'(bus.cfg_rd_data), 64'(expRd));
  endtask

  task automatic readCheck(input int q);
    applyStimulus(1'b0, 0, 2'd0, 32'h0, 1'b1, q);
  endtask

  // Request a DMA on queue q; optionally write that queue's head during the lookup cycle.
  task automatic startDma(input int q, input bit fwd, input logic [31:0] fwdData);
    bus.dma_start = 1'b1;
    bus.dma_queue = q[APP_IDX_WIDTH-1:0];
    tick();
    bus.dma_start = 1'b0;
    checkOutput("lookup_ready_low", 64'(bus.queue_ready), 64'h0);
    if (fwd) begin
      bus.cfg_wr_en    = 1'b1;
      bus.cfg_wr_queue = q[APP_IDX_WIDTH-1:0];
      bus.cfg_wr_sel   = 2'd0;
      bus.cfg_wr_data  = fwdData;
      modelWrite(q, 2'd0, fwdData);
    end
    activeQ   = q;
    snapTail  = mTail[q];
    snapKaddr = mKaddr[q];
    expReady  = 1'b1;
    tick();
    bus.cfg_wr_en = 1'b0;
    checkState();
  endtask

  // Finish the active DMA. mode 1: queue reset of the active queue in the same cycle;
  // mode 2: tail readback of the active queue in the same cycle.
  task automatic finishDma(input logic [RBW-1:0] outTail, input bit keepStart, input int nextQ, input int mode);
    bus.dma_done  = 1'b1;
    bus.out_tail  = outTail;
    bus.dma_start = keepStart;
    bus.dma_queue = nextQ[APP_IDX_WIDTH-1:0];
    mTail[activeQ] = outTail;
    if (mode == 1) begin
      bus.cfg_wr_en    = 1'b1;
      bus.cfg_wr_queue = activeQ[APP_IDX_WIDTH-1:0];
      bus.cfg_wr_sel   = 2'd2;
      bus.cfg_wr_data  = 32'h0000_0002;
      modelWrite(activeQ, 2'd2, 32'h0000_0002);
    end
    if (mode == 2) begin
      bus.cfg_rd_en    = 1'b1;
      bus.cfg_rd_queue = activeQ[APP_IDX_WIDTH-1:0];
    end
    tick();
    bus.dma_done  = 1'b0;
    bus.cfg_wr_en = 1'b0;
    bus.cfg_rd_en = 1'b0;
    expReady      = 1'b0;
    checkOutput("done_ready_low", 64'(bus.queue_ready), 64'h0);
    if (mode == 2) begin
      checkOutput("wb_fwd_valid", 64'(bus.cfg_rd_valid), 64'h1);
      checkOutput("wb_fwd_data", 64'(bus.cfg_rd_data), 64'(outTail));
    end
  endtask

  task automatic randomCycle(input bit inDma);
    int wq, rq;
    logic [1:0] sel;
    wq  = $urandom_range(0, NQ - 1);
    rq  = $urandom_range(0, NQ - 1);
    sel = 2'($urandom_range(0, 3));
    if (inDma && wq == activeQ && sel == 2'd2) sel = 2'd0;
    applyStimulus(1'($urandom_range(0, 1)), wq, sel, $urandom, 1'($urandom_range(0, 1)), rq);
  endtask

  // Bound the whole run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: run did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int nextQ, nq, nCyc;
    bit keep;

    driveIdle();
    rst      = 1'b1;
    expReady = 1'b0;
    activeQ  = 0;
    modelZero();
    tick();
    tick();
    rst = 1'b0;
    checkOutput("rst_ready", 64'(bus.queue_ready), 64'h0);
    checkOutput("rst_head", 64'(bus.head), 64'h0);
    checkOutput("rst_tail", 64'(bus.tail), 64'h0);
    checkOutput("rst_kmem", bus.kmem_addr, 64'h0);
    checkOutput("rst_rd_valid", 64'(bus.cfg_rd_valid), 64'h0);
    checkOutput("rst_rd_data", 64'(bus.cfg_rd_data), 64'h0);
    for (int q = 0; q < NQ; q++) readCheck(q);

    $display("[TB] basic lookup");
    applyStimulus(1'b1, 2, 2'd1, 32'h0000_4000, 1'b0, 0);
    applyStimulus(1'b1, 2, 2'd2, 32'h0000_0001, 1'b0, 0);
    applyStimulus(1'b1, 2, 2'd0, 32'd5, 1'b0, 0);
    applyStimulus(1'b1, 2, 2'd3, 32'hFFFF_FFFF, 1'b0, 0);
    startDma(2, 1'b0, 32'h0);
    checkOutput("basic_head", 64'(bus.head), 64'd5);
    checkOutput("basic_kmem", bus.kmem_addr, 64'h1_0000_4000);
    finishDma(RBW'(9), 1'b0, 0, 0);
    readCheck(2);
    checkOutput("basic_readback", 64'(bus.cfg_rd_data), 64'd9);

    $display("[TB] live head");
    startDma(1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1, 2'd0, 32'd30, 1'b0, 0);
    checkOutput("live_head", 64'(bus.head), 64'd30);
    applyStimulus(1'b1, 3, 2'd0, 32'd11, 1'b0, 0);
    checkOutput("other_head", 64'(bus.head), 64'd30);
    finishDma(RBW'(4), 1'b0, 0, 0);

    $display("[TB] head forward in lookup cycle");
    startDma(3, 1'b1, 32'd17);
    checkOutput("fwd_head", 64'(bus.head), 64'd17);
    finishDma(RBW'(6), 1'b0, 0, 0);

    $display("[TB] back-to-back");
    startDma(0, 1'b0, 32'h0);
    finishDma(RBW'(12), 1'b1, 1, 0);
    startDma(1, 1'b0, 32'h0);
    checkOutput("b2b_tail_q1", 64'(bus.tail), 64'd4);
    finishDma(RBW'(13), 1'b0, 0, 0);
    readCheck(0);

    $display("[TB] collisions");
    startDma(2, 1'b0, 32'h0);
    finishDma(RBW'(20), 1'b0, 0, 1);
    readCheck(2);
    checkOutput("reset_wins", 64'(bus.cfg_rd_data), 64'h0);
    startDma(3, 1'b0, 32'h0);
    finishDma(RBW'(7), 1'b0, 0, 2);

    $display("[TB] dma_done while idle");
    bus.dma_done = 1'b1;
    bus.out_tail = RBW'(99);
    tick();
    bus.dma_done = 1'b0;
    checkState();
    for (int q = 0; q < NQ; q++) readCheck(q);

    $display("[TB] randomized traffic");
    nextQ = $urandom_range(0, NQ - 1);
    for (int it = 0; it < 40; it++) begin
      startDma(nextQ, 1'($urandom_range(0, 1)), $urandom);
      nCyc = $urandom_range(0, 6);
      for (int k = 0; k < nCyc; k++) randomCycle(1'b1);
      keep = (it != 39) && ($urandom_range(0, 2) == 0);
      nq   = $urandom_range(0, NQ - 1);
      finishDma(RBW'($urandom), keep, nq, $urandom_range(0, 2));
      if (!keep) begin
        nCyc = $urandom_range(0, 3);
        for (int k = 0; k < nCyc; k++) randomCycle(1'b0);
      end
      nextQ = nq;
    end
    for (int q = 0; q < NQ; q++) readCheck(q);

    $display("[TB] reset mid-operation");
    startDma(1, 1'b0, 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    modelZero();
    expReady = 1'b0;
    checkOutput("mid_rst_ready", 64'(bus.queue_ready), 64'h0);
    checkOutput("mid_rst_head", 64'(bus.head), 64'h0);
    checkOutput("mid_rst_tail", 64'(bus.tail), 64'h0);
    checkOutput("mid_rst_kmem", bus.kmem_addr, 64'h0);
    checkOutput("mid_rst_rd_valid", 64'(bus.cfg_rd_valid), 64'h0);
    checkOutput("mid_rst_rd_data", 64'(bus.cfg_rd_data), 64'h0);
    bus.dma_done = 1'b1;
    bus.out_tail = RBW'(85);
    tick();
    bus.dma_done = 1'b0;
    checkState();
    for (int q = 0; q < NQ; q++) readCheck(q);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
